cell_tile_raster: RTL
=====================

// Module: cell_tile_raster
// PURPOSE
//  Decodes 4-bit autotile codes {rot[1:0], kind[1:0]} back into pixel art.
//  The codes are produced by the neighbourhood classifier.
//  Each accepted code is rasterised as a TILE x TILE 1-bpp bitmap, streamed one row per beat over valid/ready.
//  Sits between the tile-code map store and the frame/line buffer writer.
// PARAMETERS
//  TILE   8  tile edge in pixels; also the number of rows per tile (power of 2, >=4)
//  THICK  2  wall thickness in pixels (1 <= THICK <= TILE/2)
// PORTS
//  clk            in   1                 single clock, rising edge
//  rst_n          in   1                 asynchronous, active-low reset
//  in_code        in   4                 {rot[1:0], kind[1:0]}
//  in_valid       in   1                 code valid
//  in_ready       out  1                 code accepted when in_valid & in_ready
//  out_data       out  TILE              row pixels; bit x = column x, x=0 leftmost
//  out_row        out  $clog2(TILE)      row index, 0 = top
//  out_last       out  1                 high on row TILE-1
//  out_valid      out  1                 row beat valid
//  out_ready      in   1                 beat consumed when out_valid & out_ready
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, row=0, code reg=0, prefetch buffer empty.
//   Output reset values: out_valid=0, out_data=0, out_row=0, out_last=0, in_ready=1.
//  FSM IDLE: in_ready=1, out_valid=0. On accept: latch code, row=0, go to EMIT.
//  FSM EMIT: out_valid=1. On beat: row++.
//   Beat on row TILE-1 without a pending code -> IDLE. Row counter never wraps mid-tile.
//  Latency: code accepted at edge N -> row 0 valid in the cycle after edge N. TILE beats per tile minimum.
//  out_data, out_row and out_last are decoded from registered state only.
//   They must hold stable while out_valid & !out_ready. No row is skipped or repeated under backpressure.
//  Strip regions:
//   R = cols TILE-THICK..TILE-1; L = cols 0..THICK-1; T = rows 0..THICK-1; B = rows TILE-THICK..TILE-1.
//  Pixel = 1 when inside the region(s) for the code:
//   kind0 (none):         all zero, any rot; still emits TILE beats.
//   kind1 (edge):         rot0 R; rot1 T; rot2 L; rot3 B (full-length strip).
//   kind2 (outer corner): rot0 T&R; rot1 T&L; rot2 B&L; rot3 B&R (THICK x THICK block).
//   kind3 (inner corner): rot0 L|B; rot1 R|B; rot2 R|T; rot3 L|T (L-shaped union).
//  Reset mid-tile: the tile is abandoned; the next accepted code restarts at row 0.
//  in_code is ignored when !in_valid. X on in_code while in_valid is a bench error.
// CONFIGURATION
//  TILE_PREFETCH_EN defined:
//   Adds a one-entry code buffer, so the next tile can be accepted while the current one streams.
//   In EMIT, in_ready = !buf_full.
//   Last-row beat with buffer full: load buffer into code reg, row=0, stay in EMIT. Zero bubble between tiles.
//   Accept and last-row beat in the same cycle: the incoming code bypasses straight to the code reg. Also zero bubble.
//   Reset empties the buffer.
//  TILE_PREFETCH_EN undefined:
//   in_ready=0 throughout EMIT.
//   Exactly one idle cycle (out_valid=0) between the last beat of one tile and row 0 of the next.
// STRUCTURE
//  Package cell_tile_pkg:
//   kind constants TK_NONE=0, TK_EDGE=1, TK_OUTER=2, TK_INNER=3;
//   rot constants ROT0..ROT3;
//   code field slices (KIND=[1:0], ROT=[3:2]);
//   FSM state typedef {IDLE, EMIT}.
//  The package is shared with the classifier so both ends agree on the encoding.
//  Sub-module cell_tile_row_mask (combinational): (code, row) -> TILE-bit mask.
//   Holds the region table above; the top level holds FSM, counter and prefetch.
// TESTING (TILE=8, THICK=2)
//  1. code 4'b0001 (edge rot0), out_ready=1 ->
//     8 beats of 8'hC0; out_row 0..7; out_last only on row 7; then IDLE.
//  2. code 4'b0101 (edge rot1) -> rows0-1 8'hFF, rows2-7 8'h00.
//     code 4'b0010 (outer rot0) -> rows0-1 8'hC0, rows2-7 8'h00.
//  3. code 4'b0011 (inner rot0) -> rows0-5 8'h03, rows6-7 8'hFF.
//     code 4'b1111 (inner rot3) -> rows0-1 8'hFF, rows2-7 8'h03.
//  4. out_ready=0 for 3 cycles at row 4 of code 4'b0001 ->
//     out_row=4 and out_data=8'hC0 held; resume yields rows 5..7 exactly once.
//  5. rst_n low for 1 cycle during row 3 ->
//     out_valid/out_data/out_row go 0 immediately; next code 4'b1001 starts at row 0 (8'h03 all rows).
//  6. codes 4'b0001 then 4'b0101 with in_valid held:
//     with TILE_PREFETCH_EN, 16 consecutive beats, no gap;
//     without it, 16 beats with exactly one out_valid=0 cycle between them.

Source files
------------

// File: rtl/cell_tile_pkg.sv
// Shared autotile encoding: kind/rot constants, code field slices and raster FSM states.
// Also imported by the neighbourhood classifier so both ends agree on the code layout.
package cell_tile_pkg;

    localparam logic [1:0] TK_NONE  = 2'd0;
    localparam logic [1:0] TK_EDGE  = 2'd1;
    localparam logic [1:0] TK_OUTER = 2'd2;
    localparam logic [1:0] TK_INNER = 2'd3;

    localparam logic [1:0] ROT0 = 2'd0;
    localparam logic [1:0] ROT1 = 2'd1;
    localparam logic [1:0] ROT2 = 2'd2;
    localparam logic [1:0] ROT3 = 2'd3;

    localparam int KIND_LSB = 0;
    localparam int KIND_MSB = 1;
    localparam int ROT_LSB  = 2;
    localparam int ROT_MSB  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [1:0] code_kind(input logic [3:0] code);
        return code[KIND_MSB:KIND_LSB];
    endfunction

    function automatic logic [1:0] code_rot(input logic [3:0] code);
        return code[ROT_MSB:ROT_LSB];
    endfunction

endpackage

// File: rtl/cell_tile_row_mask.sv
// Combinational region table: (autotile code, row index) -> TILE-bit row mask.
// Bit x of the mask is column x, column 0 leftmost.
module cell_tile_row_mask
    import cell_tile_pkg::*;
#(
    parameter int TILE  = 8,
    parameter int THICK = 2,
    parameter int RW    = $clog2(TILE)
) (
    input  logic [3:0]      code,
    input  logic [RW-1:0]   row,
    output logic [TILE-1:0] mask
);

    localparam logic [TILE-1:0] ONES   = '1;
    localparam logic [TILE-1:0] L_MASK = ONES >> (TILE - THICK);
    localparam logic [TILE-1:0] R_MASK = ONES << (TILE - THICK);
    localparam logic [RW-1:0]   T_LIM  = RW'(THICK);
    localparam logic [RW-1:0]   B_LIM  = RW'(TILE - THICK);

    logic [1:0]      kind;
    logic [1:0]      rot;
    logic            in_t;
    logic            in_b;
    logic [TILE-1:0] t_row;
    logic [TILE-1:0] b_row;

    assign kind  = code_kind(code);
    assign rot   = code_rot(code);
    assign in_t  = (row < T_LIM);
    assign in_b  = (row >= B_LIM);
    // Horizontal strips cover the whole row inside their band of rows.
    assign t_row = in_t ? ONES : '0;
    assign b_row = in_b ? ONES : '0;

    always_comb begin
        mask = '0;
        case (kind)
            TK_NONE: mask = '0;
            TK_EDGE: begin
                case (rot)
                    ROT0: mask = R_MASK;
                    ROT1: mask = t_row;
                    ROT2: mask = L_MASK;
                    ROT3: mask = b_row;
                endcase
            end
            TK_OUTER: begin
                case (rot)
                    ROT0: mask = t_row & R_MASK;
                    ROT1: mask = t_row & L_MASK;
                    ROT2: mask = b_row & L_MASK;
                    ROT3: mask = b_row & R_MASK;
                endcase
            end
            TK_INNER: begin
                case (rot)
                    ROT0: mask = L_MASK | b_row;
                    ROT1: mask = R_MASK | b_row;
                    ROT2: mask = R_MASK | t_row;
                    ROT3: mask = L_MASK | t_row;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/cell_tile_raster.sv
// Autotile rasteriser: accepts 4-bit codes and streams TILE rows per code over valid/ready.
// Define TILE_PREFETCH_EN for a one-entry code buffer giving back-to-back tiles with no bubble.
module cell_tile_raster
    import cell_tile_pkg::*;
#(
    parameter int TILE  = 8,
    parameter int THICK = 2,
    parameter int RW    = $clog2(TILE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      in_code,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [TILE-1:0] out_data,
    output logic [RW-1:0]   out_row,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready,
    output state_t          dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits on ready, and payload holds while valid & !ready.

    localparam logic [RW-1:0] LAST_ROW = RW'(TILE - 1);

    state_t          state, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [3:0]      code_q, code_d;
    logic [TILE-1:0] mask;
    logic            beat;
    logic            at_last;

`ifdef TILE_PREFETCH_EN
    logic       buf_full, buf_full_d;
    logic [3:0] buf_code, buf_code_d;
    logic       accept;
`endif

    assign out_valid = (state == EMIT);
    assign beat      = out_valid & out_ready;
    assign at_last   = (row_q == LAST_ROW);
    assign out_row   = row_q;
    assign out_last  = out_valid & at_last;
    assign out_data  = out_valid ? mask : '0;
    assign dbg_state = state;

    cell_tile_row_mask #(
        .TILE  (TILE),
        .THICK (THICK),
        .RW    (RW)
    ) u_mask (
        .code (code_q),
        .row  (row_q),
        .mask (mask)
    );

    always_comb begin
        state_d  = state;
        row_d    = row_q;
        code_d   = code_q;
        in_ready = 1'b0;
`ifdef TILE_PREFETCH_EN
        buf_full_d = buf_full;
        buf_code_d = buf_code;
        accept     = 1'b0;
`endif
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    code_d  = in_code;
                    row_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
`ifdef TILE_PREFETCH_EN
                in_ready = !buf_full;
                accept   = in_valid & !buf_full;
                if (beat && at_last) begin
                    row_d = '0;
                    // Buffered code wins; an arriving code only bypasses when the buffer is empty.
                    if (buf_full) begin
                        code_d     = buf_code;
                        buf_full_d = 1'b0;
                    end else if (accept) begin
                        code_d = in_code;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (beat)
                        row_d = row_q + RW'(1);
                    if (accept) begin
                        buf_code_d = in_code;
                        buf_full_d = 1'b1;
                    end
                end
`else
                if (beat) begin
                    if (at_last) begin
                        row_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            row_q  <= '0;
            code_q <= '0;
        end else begin
            state  <= state_d;
            row_q  <= row_d;
            code_q <= code_d;
        end
    end

`ifdef TILE_PREFETCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            buf_code <= '0;
        end else begin
            buf_full <= buf_full_d;
            buf_code <= buf_code_d;
        end
    end
`endif

endmodule
